// File: rtl/nanov_spi_ram_responder.sv
// rtl/nanov_spi_ram_responder.sv - SPI READ/WRITE memory responder with host port; NANOV_SPI_FAST_READ_EN adds 0x0B fast read
module nanov_spi_ram_responder #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_BITS = $clog2(MEM_BYTES)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 spi_select,
  input  logic                 spi_clk_enable,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  input  logic                 host_we,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic [7:0]           host_rdata,
  output logic                 active
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE, DUMMY} state_t;

  state_t               state;
  logic [7:0]           mem [MEM_BYTES];
  logic [5:0]           bcnt;
  logic [2:0]           dcnt;
  logic [7:0]           cmd_sr;
  logic [7:0]           cmd_next;
  logic [7:0]           shift_out;
  logic [7:0]           rd_byte;
  logic [6:0]           wbyte;
  logic [7:0]           wbyte_next;
  logic [ADDR_BITS-1:0] addr;
  logic [ADDR_BITS-1:0] addr_eff;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 cmd_known;
  logic                 spi_edge;
  logic                 spi_wr;

  assign spi_edge   = rstn && !spi_select && spi_clk_enable;
  assign cmd_next   = {cmd_sr[6:0], spi_mosi};
  // The last address bit arrives on the same edge that launches the first data byte.
  assign addr_eff   = {addr[ADDR_BITS-2:0], spi_mosi};
  assign rd_addr    = (state == ADDR) ? addr_eff : addr;
  assign rd_byte    = mem[rd_addr];
  assign wbyte_next = {wbyte, spi_mosi};
  assign spi_wr     = spi_edge && (state == WRITE) && (dcnt == 3'd7);
  assign active     = (state != IDLE);

  always_comb begin
    cmd_known = (cmd_next == 8'h03) || (cmd_next == 8'h02);
`ifdef NANOV_SPI_FAST_READ_EN
    if (cmd_next == 8'h0B) cmd_known = 1'b1;
`endif
  end

  // SPI write is applied second so it wins a same-address collision with the host.
  always_ff @(posedge clk) begin
    if (host_we) mem[host_addr] <= host_wdata;
    if (spi_wr)  mem[addr] <= wbyte_next;
  end

  always_ff @(posedge clk) begin
    if (!rstn) host_rdata <= 8'h00;
    else       host_rdata <= mem[host_addr];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      bcnt      <= 6'd0;
      dcnt      <= 3'd0;
      cmd_sr    <= 8'h00;
      shift_out <= 8'h00;
      wbyte     <= 7'd0;
      addr      <= '0;
      spi_miso  <= 1'b0;
    end else if (spi_select) begin
      state    <= IDLE;
      spi_miso <= 1'b0;
    end else if (spi_clk_enable) begin
      case (state)
        IDLE: begin
          cmd_sr   <= {7'd0, spi_mosi};
          bcnt     <= 6'd1;
          spi_miso <= 1'b0;
          state    <= CMD;
        end
        CMD: begin
          cmd_sr <= cmd_next;
          bcnt   <= bcnt + 6'd1;
          if (bcnt == 6'd7) state <= cmd_known ? ADDR : IGNORE;
        end
        ADDR: begin
          addr <= addr_eff;
          bcnt <= bcnt + 6'd1;
          if (bcnt == 6'd31) begin
            case (cmd_sr)
              8'h03: begin
                spi_miso  <= rd_byte[7];
                shift_out <= {rd_byte[6:0], 1'b0};
                dcnt      <= 3'd1;
                addr      <= addr_eff + ADDR_BITS'(1);
                state     <= READ;
              end
              8'h02: begin
                dcnt  <= 3'd0;
                state <= WRITE;
              end
`ifdef NANOV_SPI_FAST_READ_EN
              8'h0B: state <= DUMMY;
`endif
              default: state <= IGNORE;
            endcase
          end
        end
`ifdef NANOV_SPI_FAST_READ_EN
        DUMMY: begin
          bcnt <= bcnt + 6'd1;
          if (bcnt == 6'd39) begin
            spi_miso  <= rd_byte[7];
            shift_out <= {rd_byte[6:0], 1'b0};
            dcnt      <= 3'd1;
            addr      <= addr + ADDR_BITS'(1);
            state     <= READ;
          end
        end
`endif
        READ: begin
          // dcnt wraps to 0 once the eighth bit is on the wire; then fetch the next byte.
          if (dcnt == 3'd0) begin
            spi_miso  <= rd_byte[7];
            shift_out <= {rd_byte[6:0], 1'b0};
            addr      <= addr + ADDR_BITS'(1);
          end else begin
            spi_miso  <= shift_out[7];
            shift_out <= {shift_out[6:0], 1'b0};
          end
          dcnt <= dcnt + 3'd1;
        end
        WRITE: begin
          wbyte    <= wbyte_next[6:0];
          dcnt     <= dcnt + 3'd1;
          spi_miso <= 1'b0;
          if (dcnt == 3'd7) addr <= addr + ADDR_BITS'(1);
        end
        IGNORE: spi_miso <= 1'b0;
        default: begin
          state    <= IDLE;
          spi_miso <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nanov_spi_ram_responder.sv
// tb/tb_nanov_spi_ram_responder.sv - randomized bench for nanov_spi_ram_responder against a byte-array model
module tb_nanov_spi_ram_responder;
  localparam int MB = 1024;
  localparam int AB = 10;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          spi_select = 1'b1;
  logic          spi_clk_enable = 1'b0;
  logic          spi_mosi = 1'b0;
  logic          host_we = 1'b0;
  logic [AB-1:0] host_addr = '0;
  logic [7:0]    host_wdata = 8'h00;
  logic          spi_miso;
  logic          active;
  logic [7:0]    host_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0]    model [MB];
  logic [7:0]    wbuf [8];
  logic [7:0]    rbuf [8];
  int            coll_edge = -1;
  logic [AB-1:0] coll_addr = '0;
  logic [7:0]    coll_data = 8'h00;

  nanov_spi_ram_responder #(.MEM_BYTES(MB)) dut (
    .clk(clk), .rstn(rstn), .spi_select(spi_select), .spi_clk_enable(spi_clk_enable),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .active(active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic host_wr(input logic [AB-1:0] a, input logic [7:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(posedge clk); #1;
    host_we = 1'b0;
    model[a] = d;
  endtask

  task automatic host_rd(input logic [AB-1:0] a, output logic [7:0] d);
    host_we = 1'b0; host_addr = a;
    @(posedge clk); #1;
    d = host_rdata;
  endtask

  // kind: 0 ignored command, 1 read, 2 write; data bit k is expected on miso after edge first+k
  task automatic spi_txn(input string tag, input logic [7:0] cmd, input logic [23:0] a,
                         input int nbytes, input int extra_bits, input int gap_at, input int gap_len);
    int kind, first, total, j, k;
    int bad_idle, bad_act, bad_gap;
    logic m;
    logic [7:0] d;
    bad_idle = 0; bad_act = 0; bad_gap = 0;
    first = 31;
    kind = (cmd == 8'h03) ? 1 : (cmd == 8'h02) ? 2 : 0;
`ifdef NANOV_SPI_FAST_READ_EN
    if (cmd == 8'h0B) begin kind = 1; first = 39; end
`endif
    total = (kind == 1) ? first + 8 * nbytes : 32 + 8 * nbytes + extra_bits;
    for (int i = 0; i < total; i++) begin
      spi_select = 1'b0;
      spi_clk_enable = 1'b1;
      if (i < 8) spi_mosi = cmd[7 - i];
      else if (i < 32) spi_mosi = a[31 - i];
      else if (kind == 2) begin j = i - 32; d = wbuf[j / 8]; spi_mosi = d[7 - (j % 8)]; end
      else spi_mosi = 1'($urandom);
      if (i == coll_edge) begin host_we = 1'b1; host_addr = coll_addr; host_wdata = coll_data; end
      @(posedge clk); #1;
      host_we = 1'b0;
      m = spi_miso;
      if (active !== 1'b1) bad_act++;
      if (kind == 1 && i >= first) begin
        k = i - first;
        rbuf[k / 8][7 - (k % 8)] = m;
      end else if (m !== 1'b0) bad_idle++;
      if (i == gap_at) begin
        spi_clk_enable = 1'b0;
        spi_mosi = ~spi_mosi;
        repeat (gap_len) begin
          @(posedge clk); #1;
          if (spi_miso !== m || active !== 1'b1) bad_gap++;
        end
      end
    end
    spi_select = 1'b1;
    spi_clk_enable = 1'($urandom);
    @(posedge clk); #1;
    check({tag, "_miso_zero"}, bad_idle, 0);
    check({tag, "_active"}, bad_act, 0);
    check({tag, "_gap_hold"}, bad_gap, 0);
    check({tag, "_deselect"}, {spi_miso, active}, 2'b00);
    if (coll_edge >= 0 && kind == 2) model[coll_addr] = coll_data;
    if (kind == 2)
      for (int b = 0; b < nbytes; b++) model[(int'(a) + b) % MB] = wbuf[b];
    if (kind == 1)
      for (int b = 0; b < nbytes; b++) check({tag, "_rdata"}, rbuf[b], model[(int'(a) + b) % MB]);
    else
      for (int b = 0; b <= nbytes; b++) begin
        host_rd(AB'((int'(a) + b) % MB), d);
        check({tag, "_mem"}, d, model[(int'(a) + b) % MB]);
      end
  endtask

  initial begin
    logic [7:0] d, c;
    int n, g;
    spi_select = 1'b0; spi_clk_enable = 1'b1; spi_mosi = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_miso", spi_miso, 1'b0);
    check("reset_active", active, 1'b0);
    check("reset_rdata", host_rdata, 8'h00);
    rstn = 1'b1; spi_select = 1'b1;
    for (int a = 0; a < MB; a++) host_wr(AB'(a), 8'($urandom));

    host_wr(10'h010, 8'h13); host_wr(10'h011, 8'h05); host_wr(10'h012, 8'h00); host_wr(10'h013, 8'h00);
    spi_txn("read_basic", 8'h03, 24'h000010, 4, 0, -1, 0);
    check("read_basic_b0", rbuf[0], 8'h13);

    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    spi_txn("write_basic", 8'h02, 24'h000020, 2, 0, -1, 0);
    host_rd(10'h020, d); check("write_0x20", d, 8'hA5);
    host_rd(10'h021, d); check("write_0x21", d, 8'h3C);

    c = model[10'h022];
    wbuf[0] = ~c;
    spi_txn("write_partial", 8'h02, 24'h000022, 0, 4, -1, 0);
    host_rd(10'h022, d); check("partial_0x22", d, c);

    spi_txn("read_wrap", 8'h03, 24'h0003FF, 2, 0, -1, 0);
    wbuf[0] = 8'h77;
    spi_txn("write_alias", 8'h02, 24'h010400, 1, 0, -1, 0);
    host_rd(10'h000, d); check("alias_0x000", d, 8'h77);

    spi_txn("read_gated", 8'h03, 24'h000010, 4, 0, 34, 5);
    spi_txn("unknown_cmd", 8'h9F, 24'h000010, 2, 0, 12, 3);

    wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
    coll_edge = 39; coll_addr = 10'h040; coll_data = 8'hFF;
    spi_txn("collide_same", 8'h02, 24'h000040, 2, 0, -1, 0);
    host_rd(10'h040, d); check("collide_spi_wins", d, 8'h5A);
    coll_addr = 10'h080; coll_data = 8'h81;
    spi_txn("collide_diff", 8'h02, 24'h000040, 1, 0, -1, 0);
    host_rd(10'h080, d); check("collide_host_0x80", d, 8'h81);
    coll_edge = -1;

    spi_txn("fast_read", 8'h0B, 24'h000010, 2, 0, -1, 0);

    for (int it = 0; it < 30; it++) begin
      g = $urandom_range(0, 3);
      c = (g == 0) ? 8'h03 : (g == 1) ? 8'h02 : (g == 2) ? 8'($urandom) : 8'h0B;
      if (g == 2 && (c == 8'h02 || c == 8'h03 || c == 8'h0B)) c = 8'hFF;
      n = $urandom_range(1, 4);
      for (int b = 0; b < 8; b++) wbuf[b] = 8'($urandom);
      spi_txn("rand", c, 24'($urandom), n, (c == 8'h02) ? $urandom_range(0, 7) : 0,
              ($urandom_range(0, 1) == 1) ? $urandom_range(0, 60) : -1, $urandom_range(1, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
